// File: rtl/fpu_pkg.sv
// Shared single-precision field definitions, special constants and operand
// classification used by the divide and multiply datapaths.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fclass_t;

    // Special-case outcome carried alongside an operation until the output.
    typedef struct packed {
        logic        special;
        logic [31:0] result;
        logic        dz;
    } spec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] x1;
        spec_t       sp;
    } dline_t;

    // Denormals are flushed, so any zero exponent classifies as ZERO.
    function automatic fclass_t fclassify(input logic [31:0] f);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        e = f[30:23];
        m = f[MANT_W-1:0];
        if (e == '0)
            return ZERO;
        else if (e == '1)
            return (m == '0) ? INF : NAN;
        else
            return NORMAL;
    endfunction

endpackage

// File: rtl/fmul_core.sv
// Two-stage pipelined single-precision multiplier for the normal path:
// truncating (round toward zero), flush-to-zero, saturating to signed inf.
module fmul_core
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] y
);

    logic                     va;
    logic                     sa;
    logic                     za;
    logic [24:0]              prod_a;
    logic signed [9:0]        exp_a;

    logic [24:0]              prod_c;
    logic signed [9:0]        exp_c;
    logic signed [9:0]        exp_n;
    logic [MANT_W-1:0]        mant_n;

    // Only product bits [47:23] can reach the result, so only those are kept.
    assign prod_c = 25'((48'({1'b1, a[MANT_W-1:0]}) * 48'({1'b1, b[MANT_W-1:0]})) >> MANT_W);
    assign exp_c  = 10'(a[30:23]) + 10'(b[30:23]) - 10'(EXP_BIAS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            va     <= 1'b0;
            sa     <= 1'b0;
            za     <= 1'b0;
            prod_a <= '0;
            exp_a  <= '0;
        end else begin
            // NOTE: non-blocking assignments so each stage captures the value
            // its predecessor held before this edge.
            va <= in_valid;
            if (in_valid) begin
                sa     <= a[31] ^ b[31];
                za     <= (fclassify(a) == ZERO) || (fclassify(b) == ZERO);
                prod_a <= prod_c;
                exp_a  <= exp_c;
            end
        end
    end

    // prod_a[24] is product bit 47: a carry into the 2.x range bumps the exponent.
    assign exp_n  = prod_a[24] ? exp_a + 10'sd1 : exp_a;
    assign mant_n = prod_a[24] ? prod_a[23:1] : prod_a[22:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            out_valid <= va;
            if (va) begin
                if (za || exp_n <= 10'sd0)
                    y <= {sa, 31'b0};
                else if (exp_n >= 10'sd255)
                    y <= {sa, PINF[30:0]};
                else
                    y <= {sa, exp_n[7:0], mant_n};
            end
        end
    end

endmodule

// File: rtl/fdiv_mul.sv
// Single-precision divide y = x1 * recip(x2): the divisor goes to an external
// reciprocal unit while dividend and special-case outcome ride a matching delay line.
module fdiv_mul
    import fpu_pkg::*;
#(
    parameter int RECIP_LAT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] recip_x,
    input  logic [31:0] recip_y,
    output logic        out_valid,
    output logic [31:0] y,
    output logic        dz_flag,
    input  logic        flag_clr
);

    fclass_t     c1;
    fclass_t     c2;
    logic        sgn;
    spec_t       sp_in;
    dline_t      dl_head;
    dline_t      dl     [RECIP_LAT];
    dline_t      dl_src [RECIP_LAT];
    dline_t      dl_tail;

    logic        side_va;
    spec_t       side_a;
    spec_t       side_b;
    logic        core_valid;
    logic [31:0] core_y;

    assign recip_x = x2;
    assign c1      = fclassify(x1);
    assign c2      = fclassify(x2);
    assign sgn     = x1[31] ^ x2[31];

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch.
        sp_in = '0;
        if (c1 == NAN || c2 == NAN || (c1 == ZERO && c2 == ZERO) || (c1 == INF && c2 == INF)) begin
            sp_in.special = 1'b1;
            sp_in.result  = QNAN;
        end else if (c2 == ZERO) begin
            sp_in.special = 1'b1;
            sp_in.result  = {sgn, PINF[30:0]};
            sp_in.dz      = 1'b1;
        end else if (c1 == INF) begin
            sp_in.special = 1'b1;
            sp_in.result  = {sgn, PINF[30:0]};
        end else if (c1 == ZERO || c2 == INF) begin
            sp_in.special = 1'b1;
            sp_in.result  = {sgn, 31'b0};
        end
    end

    assign dl_head = '{valid: in_valid, x1: x1, sp: sp_in};

    always_comb begin
        dl_src[0] = dl_head;
        for (int i = 1; i < RECIP_LAT; i++)
            dl_src[i] = dl[i-1];
    end

    // Only the valid bit shifts every cycle; payload moves only behind a valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the delay line is a register chain, not a RAM, so it is
            // cleared by reset along with the rest of the pipeline.
            for (int i = 0; i < RECIP_LAT; i++)
                dl[i] <= '0;
        end else begin
            for (int i = 0; i < RECIP_LAT; i++) begin
                if (dl_src[i].valid)
                    dl[i] <= dl_src[i];
                else
                    dl[i].valid <= 1'b0;
            end
        end
    end

    assign dl_tail = dl[RECIP_LAT-1];

    fmul_core u_core (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (dl_tail.valid),
        .a         (dl_tail.x1),
        .b         (recip_y),
        .out_valid (core_valid),
        .y         (core_y)
    );

    // Special outcome tracks the two multiplier stages; dz_flag is set on the
    // same edge that launches the dz result, and that set beats a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            side_va <= 1'b0;
            side_a  <= '0;
            side_b  <= '0;
            dz_flag <= 1'b0;
        end else begin
            side_va <= dl_tail.valid;
            if (dl_tail.valid)
                side_a <= dl_tail.sp;
            if (side_va)
                side_b <= side_a;
            if (side_va && side_a.dz)
                dz_flag <= 1'b1;
            else if (flag_clr)
                dz_flag <= 1'b0;
        end
    end

    assign out_valid = core_valid;
    assign y         = side_b.special ? side_b.result : core_y;

endmodule

// File: doc/fdiv_mul.md
Name: fdiv_mul

Overview:
- Downstream consumer of the table-interpolated reciprocal unit.
- Computes y = x1 / x2 as x1 * recip(x2), single precision.
- Drives the divisor to the reciprocal unit, delays the dividend, valid and special-case class to match the reciprocal latency, then multiplies in a 2-stage pipeline.
- Fully pipelined, no backpressure; one operation may issue per cycle.

Parameters:
RECIP_LAT, 3, clock cycles from recip_x to recip_y (reciprocal unit latency); legal range 1..8.

Ports:
clk  input  1  clock, all state on posedge.
rstn  input  1  asynchronous active-low reset.
in_valid  input  1  x1/x2 valid this cycle.
x1  input  32  dividend, IEEE-754 single.
x2  input  32  divisor, IEEE-754 single.
recip_x  output  32  divisor to reciprocal unit; combinational copy of x2.
recip_y  input  32  reciprocal result, RECIP_LAT cycles after recip_x.
out_valid  output  1  y valid.
y  output  32  quotient.
dz_flag  output  1  sticky divide-by-zero status.
flag_clr  input  1  synchronous clear of dz_flag.

Behaviour:
- Reset: all valid bits, out_valid, y, dz_flag and delay-line contents are cleared to 0.
- Reset mid-operation discards all in-flight operations. No out_valid is asserted until new inputs arrive.
- Latency: out_valid and y appear exactly RECIP_LAT+2 cycles after in_valid.
- Throughput: 1 per cycle. Bubbles propagate unchanged.
- Input classification happens in cycle 0, on x1/x2 only.
  - zero: exp==0, denormals flushed to zero.
  - inf: exp==255, mant==0.
  - nan: exp==255, mant!=0.
  - normal: everything else.
- Class result, precedence top to bottom:
  - any nan, 0/0, or inf/inf -> 0x7FC00000.
  - x2 zero (x1 non-zero) -> signed inf, set dz.
  - x1 inf -> signed inf.
  - x1 zero or x2 inf -> signed zero.
  - otherwise normal path.
- Sign of the special results = s1 ^ s2.
- Delay line:
  - RECIP_LAT-deep shift register of {valid, x1, special flag, special result, dz}.
  - The valid bit gates all downstream register enables except the valid chain itself.
- Multiply stage A (cycle RECIP_LAT+1):
  - Sign s = s1 ^ sr.
  - Mantissa product {1,m1}*{1,mr}, 48 bits.
  - Exponent sum e = e1 + er - 127, 10-bit signed.
- Multiply stage B (cycle RECIP_LAT+2):
  - If prod[47]: mantissa = prod[46:24], e += 1. Else mantissa = prod[45:23].
  - Truncate, round toward zero (matches the reciprocal unit's truncation).
  - e <= 0 -> signed zero.
  - e >= 255 -> signed inf.
  - Otherwise {s, e[7:0], mantissa}.
- A special flag in the pipeline overrides the multiplier result with the carried special result.
- dz_flag:
  - Set on the cycle out_valid is asserted for a dz operation.
  - flag_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- recip_y is sampled only when the matching delayed valid is 1; otherwise it is ignored.

Decomposition:
- Shared package fpu_pkg holds:
  - Field widths EXP_W=8, MANT_W=23, EXP_BIAS=127.
  - Constants QNAN=32'h7FC00000, PINF=32'h7F800000.
  - fclass_t enum {ZERO, NORMAL, INF, NAN}.
  - Function fclassify.
- One natural sub-module: fmul_core, the 2-stage pipelined normal-path multiplier with valid in/out. It is reusable by the standalone fmul.

Test Plan:
- 6.0/2.0 (x1=0x40C00000, x2=0x40000000; bench reciprocal model returns 0x3F000000 after 3 cycles) -> y=0x40400000, out_valid exactly 5 cycles after in_valid.
- Back-to-back issue: 1.0/4.0, -8.0/2.0, 3.0/0.5 on consecutive cycles -> 0x3E800000, 0xC0800000, 0x40C00000 on 3 consecutive out_valid cycles, in order.
- 1.0/+0 -> 0x7F800000 and dz_flag=1. Then flag_clr pulse -> dz_flag=0. A second dz issued in the same cycle as a flag_clr pulse keeps dz_flag=1.
- 0/0 -> 0x7FC00000. Inf/inf -> 0x7FC00000. -inf/2.0 -> 0xFF800000. 5.0/+inf -> 0x00000000. NaN/1.0 -> 0x7FC00000. None of these set dz_flag.
- Overflow/underflow: 0x7F000000 / 0x00800000 (recip model 0x7E800000) -> 0x7F800000. 0x00800000/0x7F000000 (recip model 0x00000000 treated as zero class) -> 0x00000000.
- Assert rstn low with 3 operations in flight -> no out_valid during reset or for 5 cycles after release with in_valid=0. y=0 and dz_flag=0.
